// File: rtl/imem_fetch_unit_if.sv
// Load/fetch bus between a program loader, the fetch unit and decode.
// master: loader/decode side; slave: imem_fetch_unit.
interface imem_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            load_enable;
    logic [XLEN-1:0] load_address;
    logic [XLEN-1:0] load_data;
    logic            load_error;
    logic            fetch_enable;
    logic [XLEN-1:0] base_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic            fetch_fault;
    logic            busy;

    modport master (
        output load_enable, load_address, load_data,
        output fetch_enable, base_pc, redirect_valid, redirect_pc,
        output instr_ready,
        input  load_error, instr_valid, instr_data, instr_pc,
        input  fetch_fault, busy
    );

    modport slave (
        input  load_enable, load_address, load_data,
        input  fetch_enable, base_pc, redirect_valid, redirect_pc,
        input  instr_ready,
        output load_error, instr_valid, instr_data, instr_pc,
        output fetch_fault, busy
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction memory with load port and fetch sequencer.
// Ports: clk, reset (async, active-high), bus (imem_fetch_unit_if.slave).
module imem_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 256,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h00000013)
) (
    input logic           clk,
    input logic           reset,
    imem_fetch_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, FETCH, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            lerr_q, lerr_d;
    logic            fault_q, fault_d;
    logic            busy_q, busy_d;

    logic [XLEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;

    logic          load_state;
    logic          load_addr_ok;
    logic          do_write;
    logic [AW-1:0] load_idx;
    logic [AW-1:0] pc_idx;
    logic          pc_ok;
    logic [XLEN-1:0] rd_word;

    // DEPTH is a power of two, so "index < DEPTH" means the bits
    // above the word index are all zero.
    assign load_idx     = bus.load_address[AW+1:2];
    assign load_addr_ok = (bus.load_address[1:0] == 2'b00)
                       && (bus.load_address[XLEN-1:AW+2] == '0);
    assign load_state   = (state_q == IDLE) || (state_q == LOAD);
    assign do_write     = bus.load_enable && load_state && load_addr_ok;

    assign pc_idx  = pc_q[AW+1:2];
    assign pc_ok   = (pc_q[1:0] == 2'b00) && (pc_q[XLEN-1:AW+2] == '0);
    // Words never written since reset read as a NOP.
    assign rd_word = written[pc_idx] ? mem[pc_idx] : NOP_WORD;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[load_idx] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written <= '0;
        end else if (do_write) begin
            written[load_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ipc_q   <= '0;
            lerr_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
            lerr_q  <= lerr_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        data_d  = data_q;
        ipc_d   = ipc_q;
        fault_d = fault_q;
        // Any load request that does not result in a write is an error.
        lerr_d  = bus.load_enable && !(load_state && load_addr_ok);

        unique case (state_q)
            IDLE: begin
                if (bus.load_enable) begin
                    state_d = LOAD;
                end else if (bus.fetch_enable) begin
                    state_d = FETCH;
                    pc_d    = bus.base_pc;
                end
            end
            LOAD: begin
                if (!bus.load_enable) begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (!bus.fetch_enable) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    valid_d = 1'b0;
                end else if (!valid_q || bus.instr_ready) begin
                    if (pc_ok) begin
                        data_d  = rd_word;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                    end
                end
            end
            HALT: begin
                if (!bus.fetch_enable) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FETCH) || (state_d == HALT);
    end

    assign bus.instr_valid = valid_q;
    assign bus.instr_data  = data_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.load_error  = lerr_q;
    assign bus.fetch_fault = fault_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed self-checking bench for imem_fetch_unit.
// Hand-computed expected values, checked with immediate assertions.
module tb_imem_fetch_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    imem_fetch_unit_if #(.XLEN(32)) bus ();

    imem_fetch_unit #(
        .XLEN(32),
        .DEPTH(256),
        .NOP_WORD(32'h00000013)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [31:0] pc,
                        input logic [31:0] data);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_pc"}, bus.instr_pc, pc);
        check({tag, "_data"}, bus.instr_data, data);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        bus.load_enable  = 1'b1;
        bus.load_address = a;
        bus.load_data    = d;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.load_enable    = 1'b0;
        bus.load_address   = '0;
        bus.load_data      = '0;
        bus.fetch_enable   = 1'b0;
        bus.base_pc        = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_fault", 32'(bus.fetch_fault), 32'd0);
        check("rst_lerr", 32'(bus.load_error), 32'd0);
        check("rst_data", bus.instr_data, 32'd0);
        check("rst_pc", bus.instr_pc, 32'd0);
        reset = 1'b0;
        tick();

        // Load program
        load(32'h0, 32'h00A00213);
        check("ld0_err", 32'(bus.load_error), 32'd0);
        load(32'h4, 32'h00B00293);
        load(32'h10, 32'h00428433);
        bus.load_enable = 1'b0;
        tick();
        check("ld_err", 32'(bus.load_error), 32'd0);

        // Streaming fetch
        bus.fetch_enable = 1'b1;
        bus.base_pc      = 32'h0;
        bus.instr_ready  = 1'b1;
        tick();
        check("f_entry_valid", 32'(bus.instr_valid), 32'd0);
        check("f_entry_busy", 32'(bus.busy), 32'd1);
        tick();
        beat("s0", 32'h0, 32'h00A00213);
        tick();
        beat("s4", 32'h4, 32'h00B00293);
        tick();
        beat("s8", 32'h8, 32'h00000013);
        tick();
        beat("sC", 32'hC, 32'h00000013);
        tick();
        beat("s10", 32'h10, 32'h00428433);
        bus.fetch_enable = 1'b0;
        tick();
        check("exit_valid", 32'(bus.instr_valid), 32'd0);
        check("exit_busy", 32'(bus.busy), 32'd0);

        // Backpressure
        bus.fetch_enable = 1'b1;
        tick();
        tick();
        beat("b0", 32'h0, 32'h00A00213);
        tick();
        beat("b4", 32'h4, 32'h00B00293);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat("bhold", 32'h4, 32'h00B00293);
        end
        bus.instr_ready = 1'b1;
        tick();
        beat("b8", 32'h8, 32'h00000013);
        bus.fetch_enable = 1'b0;
        tick();

        // Redirect with a pending beat
        bus.fetch_enable = 1'b1;
        tick();
        tick();
        tick();
        beat("r4", 32'h4, 32'h00B00293);
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        tick();
        check("redir_valid", 32'(bus.instr_valid), 32'd0);
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        tick();
        beat("r10", 32'h10, 32'h00428433);
        bus.fetch_enable = 1'b0;
        tick();

        // Load rejects
        load(32'h6, 32'hDEADBEEF);
        check("rej6_err", 32'(bus.load_error), 32'd1);
        load(32'h26, 32'hDEADBEEF);
        check("rej26_err", 32'(bus.load_error), 32'd1);
        load(32'h400, 32'hDEADBEEF);
        check("rej400_err", 32'(bus.load_error), 32'd1);
        bus.load_enable = 1'b0;
        tick();
        check("rej_clr", 32'(bus.load_error), 32'd0);
        bus.fetch_enable = 1'b1;
        bus.base_pc      = 32'h4;
        tick();
        tick();
        beat("rej_w4", 32'h4, 32'h00B00293);
        bus.fetch_enable = 1'b0;
        tick();
        bus.fetch_enable = 1'b1;
        bus.base_pc      = 32'h24;
        tick();
        tick();
        beat("rej_w24", 32'h24, 32'h00000013);
        bus.fetch_enable = 1'b0;
        tick();

        // Load during FETCH
        bus.fetch_enable = 1'b1;
        bus.base_pc      = 32'h28;
        bus.instr_ready  = 1'b0;
        tick();
        load(32'h2C, 32'hCAFEF00D);
        check("lf_err", 32'(bus.load_error), 32'd1);
        beat("lf28", 32'h28, 32'h00000013);
        bus.load_enable = 1'b0;
        tick();
        check("lf_clr", 32'(bus.load_error), 32'd0);
        bus.instr_ready = 1'b1;
        tick();
        beat("lf2C", 32'h2C, 32'h00000013);
        bus.fetch_enable = 1'b0;
        tick();

        // Fault at end of memory
        bus.fetch_enable = 1'b1;
        bus.base_pc      = 32'h3F8;
        tick();
        tick();
        beat("ft3F8", 32'h3F8, 32'h00000013);
        tick();
        beat("ft3FC", 32'h3FC, 32'h00000013);
        tick();
        check("ft_fault", 32'(bus.fetch_fault), 32'd1);
        check("ft_busy", 32'(bus.busy), 32'd1);
        check("ft_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("ft_sticky", 32'(bus.fetch_fault), 32'd1);
        check("ft_nobeat", 32'(bus.instr_valid), 32'd0);
        bus.fetch_enable = 1'b0;
        tick();
        check("ft_clr", 32'(bus.fetch_fault), 32'd0);
        check("ft_idle", 32'(bus.busy), 32'd0);

        // Async reset mid-stream
        bus.fetch_enable = 1'b1;
        bus.base_pc      = 32'h0;
        tick();
        tick();
        beat("ar0", 32'h0, 32'h00A00213);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(bus.instr_valid), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_pc", bus.instr_pc, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        check("ar_entry", 32'(bus.instr_valid), 32'd0);
        tick();
        beat("ar_re0", 32'h0, 32'h00000013);
        tick();
        beat("ar_re4", 32'h4, 32'h00000013);
        bus.fetch_enable = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
